// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with CTS flow control.
// Words queue in a small FIFO and go out as START/DATA/PARITY/STOP frames.
module uart_tx_fifo #(
   parameter int SYSCLK_RATE = 100000000,
   parameter int BAUD_RATE   = 9600,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 2,
   parameter int FIFO_SIZE   = 8
) (
   input  logic                         SysClk,
   input  logic                         Rst,
   input  logic [DATA_BITS-1:0]         Tx_Data,
   input  logic                         Tx_Wr,
   input  logic [1:0]                   Parity_Mode,
   input  logic                         CTS,
   input  logic                         Ovf_Clr,
   output logic                         Tx,
   output logic                         Tx_Busy,
   output logic                         Fifo_Full,
   output logic                         Fifo_Empty,
   output logic [$clog2(FIFO_SIZE):0]   Fifo_Count,
   output logic                         Overflow
);

   localparam int DIV  = SYSCLK_RATE / BAUD_RATE;
   localparam int AW   = $clog2(FIFO_SIZE);
   localparam int SCNT = STOP_BITS * DIV;
   localparam int BW   = $clog2(SCNT + 1);
   localparam int IW   = $clog2(DATA_BITS);

   localparam logic [BW-1:0] BIT_END  = BW'(DIV - 1);
   localparam logic [BW-1:0] STOP_END = BW'(SCNT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic                 r_cts_m;
   logic                 r_cts_s;
   logic [DATA_BITS-1:0] r_mem [FIFO_SIZE];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_count;
   logic                 r_ovf;
   logic [2:0]           r_state;
   logic [BW-1:0]        r_baud;
   logic [IW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic [1:0]           r_pmode;
   logic                 r_tx;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_wr;
   logic                 w_pop;
   logic                 w_start_ok;
   logic                 w_par_en;
   logic                 w_par_bit;
   logic [2:0]           w_state_nxt;
   logic [BW-1:0]        w_baud_nxt;
   logic [IW-1:0]        w_bit_nxt;
   logic                 w_tx_nxt;

   assign w_full     = (r_count == (AW+1)'(FIFO_SIZE));
   assign w_empty    = (r_count == '0);
   assign w_wr       = Tx_Wr && !w_full;
   assign w_start_ok = !w_empty && r_cts_s;
   assign w_par_en   = (r_pmode == 2'b01) || (r_pmode == 2'b10);
   assign w_par_bit  = (^r_shift) ^ r_pmode[1];

   assign Tx         = r_tx;
   assign Tx_Busy    = (r_state != S_IDLE);
   assign Fifo_Full  = w_full;
   assign Fifo_Empty = w_empty;
   assign Fifo_Count = r_count;
   assign Overflow   = r_ovf;

   // Two-flop synchroniser for the asynchronous CTS input.
   always_ff @(posedge SysClk or negedge Rst) begin
      if (!Rst) begin
         r_cts_m <= 1'b0;
         r_cts_s <= 1'b0;
      end else begin
         r_cts_m <= CTS;
         r_cts_s <= r_cts_m;
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge SysClk) begin
      if (w_wr) r_mem[r_wr_ptr] <= Tx_Data;
   end

   // FIFO pointers, occupancy and the sticky dropped-write flag.
   always_ff @(posedge SysClk or negedge Rst) begin
      if (!Rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (Tx_Wr && w_full) r_ovf <= 1'b1;
         else if (Ovf_Clr)    r_ovf <= 1'b0;
      end
   end

   // Frame sequencer: next state, bit timing and the next line level.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + 1'b1;
      w_bit_nxt   = r_bit;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_state_nxt = S_START;
               w_pop       = 1'b1;
            end
         end
         S_START: begin
            if (r_baud == BIT_END) begin
               w_state_nxt = S_DATA;
               w_bit_nxt   = '0;
            end
         end
         S_DATA: begin
            if (r_baud == BIT_END) begin
               w_baud_nxt = '0;
               if (r_bit == LAST_BIT)
                  w_state_nxt = w_par_en ? S_PARITY : S_STOP;
               else
                  w_bit_nxt = r_bit + 1'b1;
            end
         end
         S_PARITY: begin
            if (r_baud == BIT_END) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (r_baud == STOP_END) begin
               if (w_start_ok) begin
                  w_state_nxt = S_START;
                  w_pop       = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_state_nxt != r_state) w_baud_nxt = '0;
      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = r_shift[w_bit_nxt];
         S_PARITY: w_tx_nxt = w_par_bit;
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   // Sequencer state, frame word/parity latch and registered line output.
   always_ff @(posedge SysClk or negedge Rst) begin
      if (!Rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_pmode <= 2'b00;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
         if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_pmode <= Parity_Mode;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO status,
// CTS flow control and reset for uart_tx_fifo at DIV=10.
module tb_uart_tx_fifo;

   logic       SysClk;
   logic       Rst;
   logic [7:0] Tx_Data;
   logic       Tx_Wr;
   logic [1:0] Parity_Mode;
   logic       CTS;
   logic       Ovf_Clr;
   logic       Tx;
   logic       Tx_Busy;
   logic       Fifo_Full;
   logic       Fifo_Empty;
   logic [3:0] Fifo_Count;
   logic       Overflow;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_fifo #(
      .SYSCLK_RATE(96000),
      .BAUD_RATE  (9600),
      .DATA_BITS  (8),
      .STOP_BITS  (2),
      .FIFO_SIZE  (8)
   ) dut (
      .SysClk     (SysClk),
      .Rst        (Rst),
      .Tx_Data    (Tx_Data),
      .Tx_Wr      (Tx_Wr),
      .Parity_Mode(Parity_Mode),
      .CTS        (CTS),
      .Ovf_Clr    (Ovf_Clr),
      .Tx         (Tx),
      .Tx_Busy    (Tx_Busy),
      .Fifo_Full  (Fifo_Full),
      .Fifo_Empty (Fifo_Empty),
      .Fifo_Count (Fifo_Count),
      .Overflow   (Overflow)
   );

   initial begin
      SysClk = 1'b0;
      forever #5 SysClk = ~SysClk;
   end

   // Called at a negedge; the write lands on the following posedge.
   task automatic write_word(input logic [7:0] d);
      Tx_Data = d;
      Tx_Wr   = 1'b1;
      @(negedge SysClk);
      Tx_Wr   = 1'b0;
   endtask

   // Caller is positioned at the first sample of the frame.
   task automatic expect_frame(input string tag, input logic [11:0] bits,
                               input int nbits, input int drop_at,
                               input int pm_at);
      logic b;
      for (int i = 0; i < nbits * 10; i++) begin
         if (i > 0) @(negedge SysClk);
         if (i == drop_at) CTS = 1'b0;
         if (i == pm_at) Parity_Mode = ~Parity_Mode;
         b = bits[nbits - 1 - i / 10];
         n_vec++;
         if (Tx !== b || Tx_Busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s cyc %0d: Tx=%b Busy=%b, want Tx=%b Busy=1",
                     tag, i, Tx, Tx_Busy, b);
         end
      end
   endtask

   task automatic test_reset;
      Rst = 1'b0; Tx_Data = '0; Tx_Wr = 1'b0; Parity_Mode = 2'b00;
      CTS = 1'b0; Ovf_Clr = 1'b0;
      repeat (2) @(negedge SysClk);
      n_vec++;
      if ({Tx, Tx_Busy, Fifo_Empty, Fifo_Full, Fifo_Count, Overflow}
          !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset: Tx=%b Busy=%b E=%b F=%b Cnt=%0d Ovf=%b, want 1 0 1 0 0 0",
                  Tx, Tx_Busy, Fifo_Empty, Fifo_Full, Fifo_Count, Overflow);
      end
      Rst = 1'b1;
      @(negedge SysClk);
   endtask

   task automatic test_idle_after(input string tag);
      @(negedge SysClk);
      n_vec++;
      if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || Fifo_Empty !== 1'b1) begin
         n_err++;
         $display("FAIL %s idle: Tx=%b Busy=%b E=%b, want 1 0 1",
                  tag, Tx, Tx_Busy, Fifo_Empty);
      end
   endtask

   task automatic test_parity_even;
      CTS = 1'b1;
      repeat (3) @(negedge SysClk);
      Parity_Mode = 2'b01;
      write_word(8'hA5);
      n_vec++;
      if (Fifo_Count !== 4'd1 || Fifo_Empty !== 1'b0 || Tx_Busy !== 1'b0) begin
         n_err++;
         $display("FAIL enqueue: Cnt=%0d E=%b Busy=%b, want 1 0 0",
                  Fifo_Count, Fifo_Empty, Tx_Busy);
      end
      @(negedge SysClk);
      expect_frame("even", 12'b0_10100101_0_11, 12, -1, 40);
      test_idle_after("even");
   endtask

   task automatic test_parity_odd;
      Parity_Mode = 2'b10;
      write_word(8'hA5);
      @(negedge SysClk);
      expect_frame("odd", 12'b0_10100101_1_11, 12, -1, 40);
      test_idle_after("odd");
   endtask

   task automatic test_no_parity;
      Parity_Mode = 2'b00;
      write_word(8'hA5);
      @(negedge SysClk);
      expect_frame("none", 12'b0_0_10100101_11, 11, -1, -1);
      test_idle_after("none");
      Parity_Mode = 2'b11;
      write_word(8'h3C);
      @(negedge SysClk);
      expect_frame("mode11", 12'b0_0_00111100_11, 11, -1, -1);
      test_idle_after("mode11");
   endtask

   task automatic test_overflow;
      CTS = 1'b0;
      repeat (3) @(negedge SysClk);
      for (int i = 0; i < 8; i++) write_word(8'(i));
      n_vec++;
      if (Fifo_Full !== 1'b1 || Fifo_Count !== 4'd8 || Overflow !== 1'b0) begin
         n_err++;
         $display("FAIL fill: F=%b Cnt=%0d Ovf=%b, want 1 8 0",
                  Fifo_Full, Fifo_Count, Overflow);
      end
      write_word(8'h99);
      n_vec++;
      if (Fifo_Full !== 1'b1 || Fifo_Count !== 4'd8 || Overflow !== 1'b1) begin
         n_err++;
         $display("FAIL drop: F=%b Cnt=%0d Ovf=%b, want 1 8 1",
                  Fifo_Full, Fifo_Count, Overflow);
      end
      Ovf_Clr = 1'b1;
      @(negedge SysClk);
      Ovf_Clr = 1'b0;
      n_vec++;
      if (Overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_clr: Ovf=%b, want 0", Overflow);
      end
      Ovf_Clr = 1'b1;
      Tx_Wr   = 1'b1;
      @(negedge SysClk);
      Ovf_Clr = 1'b0;
      Tx_Wr   = 1'b0;
      n_vec++;
      if (Overflow !== 1'b1 || Fifo_Count !== 4'd8) begin
         n_err++;
         $display("FAIL clr_vs_drop: Ovf=%b Cnt=%0d, want 1 8",
                  Overflow, Fifo_Count);
      end
      Rst = 1'b0;
      @(negedge SysClk);
      n_vec++;
      if (Fifo_Full !== 1'b0 || Fifo_Count !== 4'd0 || Overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_reset: F=%b Cnt=%0d Ovf=%b, want 0 0 0",
                  Fifo_Full, Fifo_Count, Overflow);
      end
      Rst = 1'b1;
      @(negedge SysClk);
   endtask

   task automatic test_back_to_back;
      Parity_Mode = 2'b00;
      write_word(8'h4D);
      write_word(8'h81);
      write_word(8'h0E);
      CTS = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge SysClk);
         n_vec++;
         if (Tx_Busy !== 1'b0 || Fifo_Count !== 4'd3) begin
            n_err++;
            $display("FAIL b2b_wait %0d: Busy=%b Cnt=%0d, want 0 3",
                     i, Tx_Busy, Fifo_Count);
         end
      end
      @(negedge SysClk);
      expect_frame("b2b1", 12'b0_0_10110010_11, 11, -1, -1);
      @(negedge SysClk);
      n_vec++;
      if (Fifo_Count !== 4'd1) begin
         n_err++;
         $display("FAIL b2b_cnt2: Cnt=%0d, want 1", Fifo_Count);
      end
      expect_frame("b2b2", 12'b0_0_10000001_11, 11, -1, -1);
      @(negedge SysClk);
      n_vec++;
      if (Fifo_Empty !== 1'b1 || Fifo_Count !== 4'd0) begin
         n_err++;
         $display("FAIL b2b_empty: E=%b Cnt=%0d, want 1 0",
                  Fifo_Empty, Fifo_Count);
      end
      expect_frame("b2b3", 12'b0_0_01110000_11, 11, -1, -1);
      test_idle_after("b2b");
   endtask

   task automatic test_cts_pause;
      Parity_Mode = 2'b00;
      write_word(8'h5A);
      write_word(8'hC3);
      n_vec++;
      if (Fifo_Count !== 4'd1) begin
         n_err++;
         $display("FAIL cts_cnt: Cnt=%0d, want 1", Fifo_Count);
      end
      expect_frame("ctsA", 12'b0_0_01011010_11, 11, 30, -1);
      for (int i = 0; i < 20; i++) begin
         @(negedge SysClk);
         n_vec++;
         if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || Fifo_Count !== 4'd1) begin
            n_err++;
            $display("FAIL cts_hold %0d: Tx=%b Busy=%b Cnt=%0d, want 1 0 1",
                     i, Tx, Tx_Busy, Fifo_Count);
         end
      end
      CTS = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge SysClk);
         n_vec++;
         if (Tx !== 1'b1 || Tx_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL cts_sync %0d: Tx=%b Busy=%b, want 1 0",
                     i, Tx, Tx_Busy);
         end
      end
      @(negedge SysClk);
      expect_frame("ctsB", 12'b0_0_11000011_11, 11, -1, -1);
      test_idle_after("ctsB");
   endtask

   task automatic test_reset_midframe;
      Parity_Mode = 2'b00;
      for (int i = 0; i < 5; i++) write_word(8'h10 + 8'(i));
      n_vec++;
      if (Fifo_Count !== 4'd4) begin
         n_err++;
         $display("FAIL rm_cnt: Cnt=%0d, want 4", Fifo_Count);
      end
      repeat (12) @(negedge SysClk);
      n_vec++;
      if (Tx_Busy !== 1'b1) begin
         n_err++;
         $display("FAIL rm_busy: Busy=%b, want 1", Tx_Busy);
      end
      Rst = 1'b0;
      #1;
      n_vec++;
      if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || Fifo_Count !== 4'd0
          || Fifo_Empty !== 1'b1) begin
         n_err++;
         $display("FAIL rm_async: Tx=%b Busy=%b Cnt=%0d E=%b, want 1 0 0 1",
                  Tx, Tx_Busy, Fifo_Count, Fifo_Empty);
      end
      @(negedge SysClk);
      Rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge SysClk);
         n_vec++;
         if (Tx !== 1'b1 || Tx_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL rm_after %0d: Tx=%b Busy=%b, want 1 0",
                     i, Tx, Tx_Busy);
         end
      end
   endtask

   initial begin
      test_reset;
      test_parity_even;
      test_parity_odd;
      test_no_parity;
      test_overflow;
      test_back_to_back;
      test_cts_pause;
      test_reset_midframe;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter SYSCLK_RATE, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line rate in bit/s; DIV = SYSCLK_RATE/BAUD_RATE, integer, >= 1.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 2, legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_SIZE, default 8, power of 2, >= 2.
REQ-006 SHALL have port SysClk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port Tx_Data  input  DATA_BITS  word to enqueue.
REQ-009 SHALL have port Tx_Wr  input  1  one-cycle enqueue strobe.
REQ-010 SHALL have port Parity_Mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 SHALL have port CTS  input  1  high = far end clear to send; asynchronous.
REQ-012 SHALL have port Ovf_Clr  input  1  clears Overflow.
REQ-013 SHALL have port Tx  output  1  serial line, idle high.
REQ-014 SHALL have port Tx_Busy  output  1  high while a frame is on the line.
REQ-015 SHALL have port Fifo_Full / Fifo_Empty  output  1 each  FIFO status.
REQ-016 SHALL have port Fifo_Count  output  $clog2(FIFO_SIZE)+1  words held.
REQ-017 SHALL have port Overflow  output  1  sticky dropped-write flag.

Function
REQ-018 SHALL synchronise CTS through two SysClk flops before any use.
REQ-019 SHALL accept Tx_Wr when Fifo_Full is low at that edge; Fifo_Count increments, Fifo_Empty clears after that edge.
REQ-020 SHALL drop Tx_Wr when Fifo_Full is high at that edge (even if a pop occurs the same edge) and set Overflow.
REQ-021 SHALL, on simultaneous accepted write and pop, leave Fifo_Count unchanged; read/write pointers wrap modulo FIFO_SIZE.
REQ-022 SHALL implement FSM IDLE, START, DATA, PARITY, STOP.
REQ-023 IDLE -> START when FIFO non-empty and synchronised CTS high; the head word is popped on this edge and Parity_Mode is latched for the whole frame.
REQ-024 Each bit state SHALL hold Tx for exactly DIV cycles, counted by a baud counter reset on every state entry.
REQ-025 START drives 0; DATA drives DATA_BITS bits LSB first; PARITY (skipped when latched mode is none/11) drives XOR of data for even, its inverse for odd; STOP drives 1 for STOP_BITS x DIV cycles.
REQ-026 STOP end -> START directly (no idle cycle) if FIFO non-empty and CTS high, else -> IDLE.
REQ-027 CTS deassertion mid-frame SHALL NOT abort the frame; it only blocks the next START.
REQ-028 Tx_Busy SHALL be high in START, DATA, PARITY, STOP, low in IDLE.
REQ-029 Tx SHALL be driven from a flop (glitch-free).
REQ-030 Write to empty FIFO while IDLE with CTS synchronised high: first start-bit cycle SHALL begin 1 cycle after the write edge.
REQ-031 Ovf_Clr SHALL clear Overflow; if a dropped write coincides, Overflow stays set.
REQ-032 Parity_Mode changes during a frame SHALL affect only subsequent frames.

Reset
REQ-033 Rst low SHALL immediately force Tx=1, Tx_Busy=0, Fifo_Empty=1, Fifo_Full=0, Fifo_Count=0, Overflow=0, FSM=IDLE, pointers and counters 0, CTS synchroniser 0.
REQ-034 Reset mid-frame SHALL discard the frame and all FIFO contents; no partial frame resumes after release.

Verification (SYSCLK_RATE=96000, BAUD_RATE=9600, DIV=10, DATA_BITS=8, STOP_BITS=2, FIFO_SIZE=8)
REQ-035 Write 0xA5, Parity_Mode=01, CTS high -> Tx: 0,1,0,1,0,0,1,0,1,0,1,1, each 10 cycles, 120 cycles total; Tx_Busy high throughout.
REQ-036 Same with Parity_Mode=10 -> parity bit 1; with 00 -> 11-bit frame, 110 cycles.
REQ-037 Nine writes back-to-back, CTS low -> Fifo_Full after 8th, 9th dropped, Overflow=1, Fifo_Count=8; Ovf_Clr -> Overflow=0.
REQ-038 Three words queued, CTS high -> three frames back-to-back with no idle cycle between STOP and next START; Fifo_Empty after third pop.
REQ-039 CTS dropped during DATA of frame 1 with frame 2 queued -> frame 1 completes, Tx holds 1 until CTS returns, frame 2 starts 3 cycles after CTS rises.
REQ-040 Rst low during DATA with 4 words queued -> Tx=1, Fifo_Count=0 at once; after release Tx stays high with no writes.
